// File: rtl/pulse_width_meter.sv
// pulse_width_meter: measures runs of equal filtered samples and reports
// each completed run as a {level, length, timeout} symbol over valid/ready.
// A run at the idle level that reaches TIMEOUT samples closes the frame.
module pulse_width_meter #(
  parameter int   CNT_W      = 16,
  parameter int   TIMEOUT    = 255,
  parameter logic IDLE_LEVEL = 1'b1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clear_n,
  input  logic             i_value,
  input  logic             i_valid,
  output logic             o_level,
  output logic [CNT_W-1:0] o_length,
  output logic             o_timeout,
  output logic             o_valid,
  input  logic             i_ready,
  output logic             o_overflow
);

  localparam logic [CNT_W-1:0] CNT_MAX   = '1;
  localparam logic [CNT_W-1:0] TIMEOUT_C = CNT_W'(TIMEOUT);
  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

  typedef enum logic {IDLE, MEASURE} state_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             lvl_q, lvl_d;
  logic             valid_q, valid_d;
  logic             level_q, level_d;
  logic [CNT_W-1:0] length_q, length_d;
  logic             timeout_q, timeout_d;
  logic             ovf_q, ovf_d;

  logic             emit;
  logic             em_level;
  logic [CNT_W-1:0] em_length;
  logic             em_timeout;
  logic [CNT_W-1:0] cnt_inc;

  // State, run counter and output register; rst and clear_n both return to IDLE
  always_ff @(posedge clk) begin
    if (rst || !clear_n) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      lvl_q     <= 1'b0;
      valid_q   <= 1'b0;
      level_q   <= 1'b0;
      length_q  <= '0;
      timeout_q <= 1'b0;
      ovf_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      lvl_q     <= lvl_d;
      valid_q   <= valid_d;
      level_q   <= level_d;
      length_q  <= length_d;
      timeout_q <= timeout_d;
      ovf_q     <= ovf_d;
    end
  end

  // Run measurement: decides the next run state and whether a symbol ends here
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    lvl_d      = lvl_q;
    emit       = 1'b0;
    em_level   = lvl_q;
    em_length  = cnt_q;
    em_timeout = 1'b0;
    cnt_inc    = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + CNT_ONE;
    if (i_valid) begin
      unique case (state_q)
        IDLE: begin
          if (i_value != IDLE_LEVEL) begin
            state_d = MEASURE;
            lvl_d   = i_value;
            cnt_d   = CNT_ONE;
          end
        end
        MEASURE: begin
          if (i_value == lvl_q) begin
            if (lvl_q == IDLE_LEVEL && cnt_inc == TIMEOUT_C) begin
              // Idle line held long enough: frame is over
              emit       = 1'b1;
              em_level   = IDLE_LEVEL;
              em_length  = TIMEOUT_C;
              em_timeout = 1'b1;
              state_d    = IDLE;
              cnt_d      = '0;
            end else begin
              cnt_d = cnt_inc;
            end
          end else begin
            // Level change closes the current run and opens the next one
            emit  = 1'b1;
            lvl_d = i_value;
            cnt_d = CNT_ONE;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  // Single-entry output register: load when free or being drained, else drop
  always_comb begin
    valid_d   = valid_q;
    level_d   = level_q;
    length_d  = length_q;
    timeout_d = timeout_q;
    ovf_d     = ovf_q;
    if (emit && (!valid_q || i_ready)) begin
      valid_d   = 1'b1;
      level_d   = em_level;
      length_d  = em_length;
      timeout_d = em_timeout;
    end else if (emit) begin
      ovf_d = 1'b1;
    end else if (valid_q && i_ready) begin
      valid_d = 1'b0;
    end
  end

  assign o_valid    = valid_q;
  assign o_level    = level_q;
  assign o_length   = length_q;
  assign o_timeout  = timeout_q;
  assign o_overflow = ovf_q;

endmodule
